// File: rtl/ddr3_burst_pkg.sv
// Shared types and constants for the DDR3 burst write/read-back exerciser.
// Used by ddr3_burst_rw and ddr3_burst_pattern.
package ddr3_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } burst_state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam int         PAT_W  = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr3_burst_pattern.sv
// Combinational test-pattern generator: {pass_cnt, beat_idx} replicated across
// the full MIG data word.
module ddr3_burst_pattern
    import ddr3_burst_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic [15:0]       pass_cnt,
    input  logic [15:0]       beat_idx,
    output logic [DATA_W-1:0] word
);

    localparam int REPS = DATA_W / PAT_W;

    logic [PAT_W-1:0] unit;

    assign unit = {pass_cnt, beat_idx};
    assign word = {REPS{unit}};

endmodule

// File: rtl/ddr3_burst_rw.sv
// Writes BURST_LEN pattern beats through the MIG user interface, reads them back
// and counts passes. Define DDR3_BURST_RW_CHECK_EN to compare returned read data.
module ddr3_burst_rw
    import ddr3_burst_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 512,
    parameter int BURST_LEN = 64,
    parameter int ADDR_STEP = 8
) (
    input  logic                ui_clk,
    input  logic                rst_n,
    input  logic                init_calib_complete,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    input  logic                app_rd_data_end,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         err_cnt,
    output logic [15:0]         pass_cnt
);

    localparam logic [15:0]       LAST_BEAT = 16'(BURST_LEN - 1);
    localparam logic [15:0]       BURST_CNT = 16'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    burst_state_t      state;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_cmd_cnt;
    logic [15:0]       rd_dat_cnt;
    logic [15:0]       wr_idx_next;
    logic [15:0]       rd_dat_next;
    logic [DATA_W-1:0] wr_pattern;
    logic              rd_beat;
    logic              calib_lost;
    logic              chk_mismatch;

    // Pattern for the beat about to be presented: beat 0 on launch, else the next one.
    assign wr_idx_next = (state == ST_IDLE) ? 16'd0 : wr_cnt + 16'd1;

    ddr3_burst_pattern #(.DATA_W(DATA_W)) u_wr_pattern (
        .pass_cnt (pass_cnt),
        .beat_idx (wr_idx_next),
        .word     (wr_pattern)
    );

    assign rd_beat     = app_rd_data_valid && (state == ST_READ || state == ST_DRAIN)
                         && (rd_dat_cnt != BURST_CNT);
    assign rd_dat_next = rd_dat_cnt + {15'd0, rd_beat};
    assign calib_lost  = !init_calib_complete
                         && (state == ST_WRITE || state == ST_READ || state == ST_DRAIN);
    assign app_wdf_mask = '0;

`ifdef DDR3_BURST_RW_CHECK_EN
    logic [DATA_W-1:0] chk_pattern;
    logic [15:0]       err_cnt_q;
    logic              unused_rd_inputs;

    // Returned data arrives in command order, so the returned-beat count is its index.
    ddr3_burst_pattern #(.DATA_W(DATA_W)) u_chk_pattern (
        .pass_cnt (pass_cnt),
        .beat_idx (rd_dat_cnt),
        .word     (chk_pattern)
    );

    assign chk_mismatch     = rd_beat && (app_rd_data != chk_pattern);
    assign err_cnt          = err_cnt_q;
    assign unused_rd_inputs = &{1'b0, app_rd_data_end};
`else
    logic unused_rd_inputs;

    assign chk_mismatch     = 1'b0;
    assign err_cnt          = '0;
    assign unused_rd_inputs = &{1'b0, app_rd_data, app_rd_data_end};
`endif

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            base_q       <= '0;
            wr_cnt       <= '0;
            rd_cmd_cnt   <= '0;
            rd_dat_cnt   <= '0;
            app_addr     <= '0;
            app_cmd      <= CMD_WR;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pass_cnt     <= '0;
`ifdef DDR3_BURST_RW_CHECK_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (rd_beat) begin
                rd_dat_cnt <= rd_dat_next;
            end

            if (calib_lost) begin
                // Calibration lost: abandon the pass without a done pulse.
                state        <= ST_IDLE;
                app_en       <= 1'b0;
                app_wdf_wren <= 1'b0;
                app_wdf_end  <= 1'b0;
                busy         <= 1'b0;
                err          <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && init_calib_complete) begin
                            state        <= ST_WRITE;
                            base_q       <= base_addr;
                            wr_cnt       <= '0;
                            rd_cmd_cnt   <= '0;
                            rd_dat_cnt   <= '0;
                            app_addr     <= base_addr;
                            app_cmd      <= CMD_WR;
                            app_wdf_data <= wr_pattern;
                            app_en       <= 1'b1;
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end

                    ST_WRITE: begin
                        if (app_rdy && app_wdf_rdy) begin
                            if (wr_cnt == LAST_BEAT) begin
                                state        <= ST_READ;
                                app_wdf_wren <= 1'b0;
                                app_wdf_end  <= 1'b0;
                                app_cmd      <= CMD_RD;
                                app_addr     <= base_q;
                            end else begin
                                wr_cnt       <= wr_idx_next;
                                app_addr     <= app_addr + STEP;
                                app_wdf_data <= wr_pattern;
                            end
                        end
                    end

                    ST_READ: begin
                        if (app_rdy) begin
                            rd_cmd_cnt <= rd_cmd_cnt + 16'd1;
                            if (rd_cmd_cnt == LAST_BEAT) begin
                                state  <= ST_DRAIN;
                                app_en <= 1'b0;
                            end else begin
                                app_addr <= app_addr + STEP;
                            end
                        end
                    end

                    ST_DRAIN: begin
                        if (rd_dat_next == BURST_CNT) begin
                            state    <= ST_FIN;
                            done     <= 1'b1;
                            pass_cnt <= pass_cnt + 16'd1;
                        end
                    end

                    ST_FIN: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end

`ifdef DDR3_BURST_RW_CHECK_EN
            if (chk_mismatch) begin
                err       <= 1'b1;
                err_cnt_q <= sat_inc16(err_cnt_q);
            end
`endif
        end
    end

endmodule
